add_a_to_output: RTL and testbench

- Pipelined unsigned accumulator: each accepted input operand `a` is added into an output register `acc`.
- 1-bit `out` is a sticky overflow flag that reports any carry out of the accumulator since the last reset/clear.
- Sits as a leaf datapath block; `out` is the primary status output compared at top level.
- Supports wrap-around or saturating arithmetic, selected at run time.

---
 rtl/add_a_to_output.sv | 86 ++++++++
 tb/tb_add_a_to_output.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/add_a_to_output.sv
// add_a_to_output
//   Two-stage pipelined unsigned accumulator with a sticky overflow flag.
//   Stage 1 captures an accepted operand; stage 2 adds it into acc, either
//   wrapping modulo 2^WIDTH or saturating at all ones (sat_en, sampled at the
//   commit edge). Any carry out of the add sets the sticky flag `out`.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous clear; clears acc/out and flushes stage 1
//   in_valid   operand `a` presented this cycle
//   in_ready   operand can be accepted this cycle (low during clr)
//   a          unsigned operand
//   sat_en     1 = saturate on overflow, 0 = wrap
//   acc        registered accumulated value
//   acc_valid  one-cycle pulse: acc was updated at the preceding edge
//   out        sticky overflow flag (registered)
module add_a_to_output #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             sat_en,
  output logic [WIDTH-1:0] acc,
  output logic             acc_valid,
  output logic             out
);

  logic             ready_q;
  logic             v_q;
  logic [WIDTH-1:0] a_q;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_next;

  // ready_q rises on the first edge after reset release and then stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign in_ready = ready_q & ~clr;
  assign accept   = in_valid & in_ready;

  // Stage 1: operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      a_q <= '0;
    end else begin
      v_q <= accept;
      if (accept) a_q <= a;
    end
  end

  // Stage 2 arithmetic always works off the live acc register, so
  // back-to-back operands need no forwarding.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, a_q};
    acc_next = sum[WIDTH-1:0];
    if (sum[WIDTH] && sat_en) acc_next = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      acc_valid <= 1'b0;
      out       <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      acc_valid <= 1'b0;
      out       <= 1'b0;
    end else if (v_q) begin
      acc       <= acc_next;
      acc_valid <= 1'b1;
      out       <= out | sum[WIDTH];
    end else begin
      acc_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_a_to_output.sv
// tb_add_a_to_output
//   Directed scenarios plus randomized traffic against an integer-arithmetic
//   reference model of the accumulator (pending operands held in a queue).
module tb_add_a_to_output;

  localparam int unsigned WIDTH = 8;
  localparam int MAXV = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             sat_en;
  logic [WIDTH-1:0] acc;
  logic             acc_valid;
  logic             out;

  add_a_to_output #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .sat_en    (sat_en),
    .acc       (acc),
    .acc_valid (acc_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_acc;
  bit m_ovf;
  bit m_valid;
  bit m_ready;
  int m_pend[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_acc = 0; m_ovf = 0; m_valid = 0; m_ready = 0;
    m_pend.delete();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".acc"}, int'(acc), m_acc);
    check({tag, ".acc_valid"}, int'(acc_valid), int'(m_valid));
    check({tag, ".out"}, int'(out), int'(m_ovf));
  endtask

  // One clock cycle: drive inputs away from the edge, check in_ready,
  // advance the model at the edge, check registered outputs just after.
  task automatic cycle(input bit c, input bit v, input int op, input bit s, input string tag);
    int x, total;
    clr = c; in_valid = v; a = WIDTH'(op); sat_en = s;
    #1;
    check({tag, ".in_ready"}, int'(in_ready), int'(m_ready && !c));
    @(posedge clk);
    if (c) begin
      m_acc = 0; m_ovf = 0; m_valid = 0;
      m_pend.delete();
    end else begin
      if (m_pend.size() > 0) begin
        x = m_pend.pop_front();
        total = m_acc + x;
        if (total > MAXV) begin
          m_ovf = 1;
          m_acc = s ? MAXV : total - (MAXV + 1);
        end else begin
          m_acc = total;
        end
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (m_ready && v) m_pend.push_back(op & MAXV);
    end
    m_ready = 1;
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit s, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, s, tag);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a = '0; sat_en = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    check("reset.in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    idle(2, 0, "idle");

    // Back-to-back accumulate
    cycle(0, 1, 'h10, 0, "b2b0");
    cycle(0, 1, 'h20, 0, "b2b1");
    idle(1, 0, "b2b2");
    check("b2b.final_acc", int'(acc), 'h30);

    // Wrap
    cycle(1, 0, 0, 0, "wclr");
    cycle(0, 1, 'hF0, 0, "w0");
    cycle(0, 1, 'h20, 0, "w1");
    idle(1, 0, "w2");
    check("wrap.acc", int'(acc), 'h10);
    check("wrap.out", int'(out), 1);
    cycle(0, 1, 'h01, 0, "w3");
    idle(1, 0, "w4");
    check("wrap.acc2", int'(acc), 'h11);
    check("wrap.sticky", int'(out), 1);

    // Saturate
    cycle(1, 0, 0, 1, "sclr");
    cycle(0, 1, 'hF0, 1, "s0");
    cycle(0, 1, 'h20, 1, "s1");
    idle(1, 1, "s2");
    check("sat.acc", int'(acc), 'hFF);
    check("sat.out", int'(out), 1);
    cycle(0, 1, 'h05, 1, "s3");
    idle(1, 1, "s4");
    check("sat.acc2", int'(acc), 'hFF);

    // Zero operand still pulses acc_valid
    cycle(1, 0, 0, 0, "zclr");
    cycle(0, 1, 0, 0, "z0");
    idle(1, 0, "z1");
    check("zero.pulse", int'(acc_valid), 1);

    // clr while an operand sits in stage 1, with in_valid still high
    cycle(0, 1, 'h40, 0, "c0");
    cycle(0, 1, 'h11, 0, "c1");
    cycle(1, 1, 'h22, 0, "c2");
    check("clr.acc", int'(acc), 0);
    check("clr.no_pulse", int'(acc_valid), 0);
    idle(2, 0, "c3");

    // Carry and clr in the same cycle leave out=0
    cycle(0, 1, 'hFF, 0, "cc0");
    cycle(0, 1, 'h02, 0, "cc1");
    cycle(1, 0, 0, 0, "cc2");
    check("clrcarry.out", int'(out), 0);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(15) == 0), ($urandom_range(3) != 0),
            int'($urandom_range(MAXV)), bit'($urandom_range(1)), "rnd");
    end

    // Asynchronous reset between edges, mid-stream
    cycle(0, 1, 'h80, 0, "ar0");
    cycle(0, 1, 'h90, 0, "ar1");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1, 'h07, 0, "post0");
    cycle(0, 1, 'h03, 0, "post1");
    idle(1, 0, "post2");
    check("post.acc", int'(acc), 'h03);

    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(31) == 0), ($urandom_range(3) != 0),
            int'($urandom_range(MAXV)), bit'($urandom_range(1)), "rnd2");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
